// File: rtl/riscv_mem_pkg.sv
// Shared types for the riscv_mem_ctrl slice: port identifiers, response tag
// carried down the read-latency pipeline, and the latency ceiling.
package riscv_mem_pkg;

  localparam int MAX_RD_LATENCY = 4;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
  } rsp_tag_t;

endpackage

// File: rtl/riscv_mem_rr_arb.sv
// Two-requester round-robin arbiter. Grant is combinational in the request
// cycle; the registered last-winner pointer decides ties. After reset the
// pointer reads "instr won last", which hands the first tie to the data port.
module riscv_mem_rr_arb
  import riscv_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_e      winner
);

  port_e last_q;

  // Pick one requester; on a tie the port that did not win last goes.
  always_comb begin
    gnt    = 2'b00;
    winner = PORT_DATA;
    if (!rst) begin
      if (req[PORT_DATA] && (!req[PORT_INSTR] || last_q == PORT_INSTR)) begin
        gnt[PORT_DATA] = 1'b1;
        winner         = PORT_DATA;
      end else if (req[PORT_INSTR]) begin
        gnt[PORT_INSTR] = 1'b1;
        winner          = PORT_INSTR;
      end
    end
  end

  // Remember who was served so the other side wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PORT_INSTR;
    end else if (|gnt) begin
      last_q <= winner;
    end
  end

endmodule

// File: rtl/riscv_mem_ctrl.sv
// Dual-port (fetch + load/store) front end to a single-port word array.
// One access per cycle, round-robin between ports, responses returned a fixed
// RD_LATENCY cycles after grant. Optional macro MEM_RANGE_ERR_EN turns
// out-of-range addresses into error responses instead of wrapping them.
module riscv_mem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8192,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  output logic                    instr_err_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_WIDTH / 8;

  logic [1:0]            req;
  logic [1:0]            gnt;
  port_e                 winner;
  logic                  granted;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [IDX_W-1:0]      idx;
  logic                  range_err;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_pipe [MAX_RD_LATENCY];
  rsp_tag_t              tag_pipe  [MAX_RD_LATENCY];
  rsp_tag_t              out_tag;
  logic [DATA_WIDTH-1:0] out_data;

  assign req[PORT_INSTR] = instr_req_i;
  assign req[PORT_DATA]  = data_req_i;

  riscv_mem_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .winner (winner)
  );

  assign instr_gnt_o = gnt[PORT_INSTR];
  assign data_gnt_o  = gnt[PORT_DATA];
  assign granted     = |gnt;

  assign sel_addr = (winner == PORT_DATA) ? data_addr_i : instr_addr_i;
  assign sel_we   = (winner == PORT_DATA) && data_we_i;
  assign idx      = sel_addr[IDX_W+1:2];

`ifdef MEM_RANGE_ERR_EN
  assign range_err = granted &&
                     ({2'b00, sel_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH));
`else
  assign range_err = 1'b0;
`endif

  // Byte-masked write and registered read; the read register is the first
  // data stage, so only responses to clean reads carry non-zero data.
  always_ff @(posedge clk) begin
    if (granted && sel_we && !range_err) begin
      for (int b = 0; b < NB; b++) begin
        if (data_be_i[b]) begin
          mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
    data_pipe[0] <= (granted && !sel_we && !range_err) ? mem[idx] : '0;
    for (int s = 1; s < MAX_RD_LATENCY; s++) begin
      data_pipe[s] <= data_pipe[s-1];
    end
  end

  // Response tags ride alongside the data; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MAX_RD_LATENCY; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: granted, port: winner, err: range_err};
      for (int s = 1; s < MAX_RD_LATENCY; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  assign out_tag  = tag_pipe[RD_LATENCY-1];
  assign out_data = data_pipe[RD_LATENCY-1];

  // Outputs are also gated by rst so they read zero for the whole reset
  // cycle, not just after the first reset edge.
  assign instr_rvalid_o = !rst && out_tag.valid && (out_tag.port == PORT_INSTR);
  assign data_rvalid_o  = !rst && out_tag.valid && (out_tag.port == PORT_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? out_data : '0;
  assign data_rdata_o   = data_rvalid_o ? out_data : '0;

`ifdef MEM_RANGE_ERR_EN
  assign instr_err_o = instr_rvalid_o && out_tag.err;
  assign data_err_o  = data_rvalid_o && out_tag.err;
`else
  assign instr_err_o = 1'b0;
  assign data_err_o  = 1'b0;
`endif

  // Word-aligned access ignores the byte offset; without the range check the
  // high address bits wrap and the error tag stays constant.
  logic unused_bits;
  assign unused_bits = ^{sel_addr[1:0], sel_addr[ADDR_WIDTH-1:IDX_W+2], out_tag.err};

endmodule

// File: doc/riscv_mem_ctrl.md
RISCV_MEM_CTRL -- requirements
Module: riscv_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width on both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 8192, words of storage; power of two.
REQ-004 SHALL have parameter RD_LATENCY, default 1, cycles from grant to rvalid; legal range 1..4.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have ports instr_req_i in 1, instr_gnt_o out 1, instr_addr_i in ADDR_WIDTH: fetch request, grant, byte address.
REQ-009 SHALL have ports instr_rvalid_o out 1, instr_rdata_o out DATA_WIDTH, instr_err_o out 1: fetch response.
REQ-010 SHALL have ports data_req_i in 1, data_gnt_o out 1, data_addr_i in ADDR_WIDTH, data_we_i in 1, data_be_i in DATA_WIDTH/8, data_wdata_i in DATA_WIDTH: load/store request.
REQ-011 SHALL have ports data_rvalid_o out 1, data_rdata_o out DATA_WIDTH, data_err_o out 1: load/store response.

Function
REQ-012 SHALL hold one single-port word array of DEPTH entries, indexed by addr[$clog2(DEPTH)+1:2]; addr[1:0] ignored.
REQ-013 SHALL accept at most one request per cycle; gnt is combinational in the cycle req is high and the port wins.
REQ-014 SHALL grant immediately with no contention; when both ports request, the port not granted last wins (round-robin); after reset data port has priority.
REQ-015 SHALL keep the losing request pending; master holds req/addr/wdata stable until gnt.
REQ-016 SHALL return exactly one rvalid per grant, exactly RD_LATENCY cycles after the grant cycle, on the granting port, in grant order.
REQ-017 SHALL present read data with rvalid; for writes rvalid is an acknowledge and rdata is 0.
REQ-018 SHALL write only bytes with be bit set; be=0 write is a no-op that is still acknowledged.
REQ-019 SHALL return new data for a read granted the cycle after a write to the same word.
REQ-020 SHALL support fully pipelined back-to-back grants (one per cycle) with no bubbles.
REQ-021 SHALL carry port-id and error tag through a RD_LATENCY-deep pipeline; rdata of the idle port is 0.

Reset
REQ-022 SHALL drive all gnt, rvalid, err outputs to 0 and rdata to 0 while rst is high.
REQ-023 SHALL discard in-flight responses on reset; no rvalid appears for requests granted before or during reset.
REQ-024 SHALL not clear array contents on reset; round-robin pointer returns to data priority.

Configuration
REQ-025 SHALL, with MEM_RANGE_ERR_EN defined, flag a request whose addr[ADDR_WIDTH-1:2] >= DEPTH: granted normally, no array write, rvalid with err=1 and rdata=0 at normal latency.
REQ-026 SHALL, without MEM_RANGE_ERR_EN, wrap out-of-range addresses modulo DEPTH and tie both err outputs to 0.

Structure
REQ-027 SHALL take from package riscv_mem_pkg: port-id enum (PORT_INSTR, PORT_DATA), response-tag struct (valid, port, err), MAX_RD_LATENCY=4.
REQ-028 SHALL put arbitration in sub-module riscv_mem_rr_arb (2 requesters, registered last-winner pointer).

Verification
REQ-029 SHALL test: RD_LATENCY=1, data write 0xDEADBEEF be=4'hF @0x100, then instr read @0x100 -> instr_rvalid 1 cycle after grant, rdata 0xDEADBEEF.
REQ-030 SHALL test: write 0x11223344 then be=4'b0010 write 0x0000AA00 @0x40, read -> 0x1122AA44.
REQ-031 SHALL test: both ports request continuously 8 cycles after reset -> grants alternate D,I,D,I...; 4 per port, responses in grant order.
REQ-032 SHALL test: RD_LATENCY=3, 5 back-to-back data reads -> 5 consecutive rvalids starting 3 cycles after first grant.
REQ-033 SHALL test: reset asserted 1 cycle after a grant with RD_LATENCY=2 -> no rvalid on either port; prior array data still readable.
REQ-034 SHALL test: MEM_RANGE_ERR_EN, DEPTH=8192, write @0x8000 -> data_err_o=1 with rvalid, word 0 unchanged; without macro, same write lands in word 0.
